decode_stage_buffer: RTL and testbench



---
 rtl/decode_stage_buffer.sv | 152 +++++++++++++++
 tb/tb_decode_stage_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_buffer.sv
// Purpose : decode-to-execute pipeline register with a 2-entry skid buffer, valid/ready handshake and branch flush.
// Latency : 1 cycle from in_fire to out_valid when empty (or busy and draining); 1 entry/cycle while out_ready=1.
// Backpres: in_ready drops only when both entries are held; it and out_valid are decoded from registered state.
//
// Ports: clk/rst_n (async active-low), flush_in (synchronous, drops both entries and any incoming entry),
//        in_valid/in_ready + pc/instruction/rd/rs1/rs2/ctrl inputs, out_valid/out_ready + head-entry outputs.
// Optional: define DECODE_STAGE_BUFFER_STATS_EN to add saturating stall_cycles_out / bubble_cycles_out
//           counters (STAT_WIDTH bits each, cleared only by reset).
module decode_stage_buffer #(
    parameter int WORD_SIZE      = 32,
    parameter int REGISTER_INDEX = 5,
    parameter int CTRL_WIDTH     = 8,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_SIZE-1:0]      pc_in,
    input  logic [WORD_SIZE-1:0]      instruction_in,
    input  logic [REGISTER_INDEX-1:0] rd_in,
    input  logic [REGISTER_INDEX-1:0] rs1_in,
    input  logic [REGISTER_INDEX-1:0] rs2_in,
    input  logic [CTRL_WIDTH-1:0]     ctrl_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_SIZE-1:0]      pc_out,
    output logic [WORD_SIZE-1:0]      instruction_out,
    output logic [REGISTER_INDEX-1:0] rd_out,
    output logic [REGISTER_INDEX-1:0] rs1_out,
    output logic [REGISTER_INDEX-1:0] rs2_out,
    output logic [CTRL_WIDTH-1:0]     ctrl_out
`ifdef DECODE_STAGE_BUFFER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]     stall_cycles_out,
    output logic [STAT_WIDTH-1:0]     bubble_cycles_out
`endif
);

    // Whole entry carried as one flat vector: {pc, instr, rd, rs1, rs2, ctrl}.
    localparam int PW = 2*WORD_SIZE + 3*REGISTER_INDEX + CTRL_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic [PW-1:0]   in_dat;
    logic            in_fire;
    logic            out_fire;

    assign in_dat = {pc_in, instruction_in, rd_in, rs1_in, rs2_in, ctrl_in};

    // Handshake flags come straight from the state register, so nothing on the
    // input side can reach out_valid/in_ready combinationally.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_in) begin
            // Payload left as-is; only the state matters once emptied.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_BUSY;
                        main_d  = in_dat;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_dat;
                    end else if (in_fire) begin
                        // Head is stalled: park the newcomer behind it.
                        state_d = ST_FULL;
                        skid_d  = in_dat;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign ctrl_out        = out_valid ? main_q[CTRL_WIDTH-1:0] : '0;
    assign rs2_out         = main_q[CTRL_WIDTH +: REGISTER_INDEX];
    assign rs1_out         = main_q[CTRL_WIDTH + REGISTER_INDEX +: REGISTER_INDEX];
    assign rd_out          = main_q[CTRL_WIDTH + 2*REGISTER_INDEX +: REGISTER_INDEX];
    assign instruction_out = main_q[CTRL_WIDTH + 3*REGISTER_INDEX +: WORD_SIZE];
    assign pc_out          = main_q[CTRL_WIDTH + 3*REGISTER_INDEX + WORD_SIZE +: WORD_SIZE];

`ifdef DECODE_STAGE_BUFFER_STATS_EN
    logic [STAT_WIDTH-1:0] stall_q, stall_d;
    logic [STAT_WIDTH-1:0] bubble_q, bubble_d;

    // Saturating counters; flush deliberately does not clear them.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (!out_valid && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cycles_out  = stall_q;
    assign bubble_cycles_out = bubble_q;
`endif

endmodule

// File: tb/tb_decode_stage_buffer.sv
// Purpose : randomized + directed bench for decode_stage_buffer with a queue-based reference model.
// Latency : driver issues one stimulus set per cycle; monitor checks every falling edge.
// Backpres: random out_ready and flush exercise stall, skid and drop paths.
module tb_decode_stage_buffer;

    localparam int WS = 32;
    localparam int RI = 5;
    localparam int CW = 8;
    localparam int SW = 2;

    typedef struct packed {
        logic [WS-1:0] pc;
        logic [WS-1:0] instr;
        logic [RI-1:0] rd;
        logic [RI-1:0] rs1;
        logic [RI-1:0] rs2;
        logic [CW-1:0] ctrl;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          flush_in;
    logic          in_valid;
    logic          in_ready;
    logic [WS-1:0] pc_in;
    logic [WS-1:0] instruction_in;
    logic [RI-1:0] rd_in;
    logic [RI-1:0] rs1_in;
    logic [RI-1:0] rs2_in;
    logic [CW-1:0] ctrl_in;
    logic          out_valid;
    logic          out_ready;
    logic [WS-1:0] pc_out;
    logic [WS-1:0] instruction_out;
    logic [RI-1:0] rd_out;
    logic [RI-1:0] rs1_out;
    logic [RI-1:0] rs2_out;
    logic [CW-1:0] ctrl_out;
`ifdef DECODE_STAGE_BUFFER_STATS_EN
    logic [SW-1:0] stall_cycles_out;
    logic [SW-1:0] bubble_cycles_out;
`endif

    decode_stage_buffer #(
        .WORD_SIZE(WS), .REGISTER_INDEX(RI), .CTRL_WIDTH(CW), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instruction_out(instruction_out),
        .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .ctrl_out(ctrl_out)
`ifdef DECODE_STAGE_BUFFER_STATS_EN
        , .stall_cycles_out(stall_cycles_out), .bubble_cycles_out(bubble_cycles_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a FIFO of capacity two. exp_occ is its occupancy as seen
    // by the upcoming clock edge (before this cycle's push/pop).
    ent_t sb_q[$];
    int   exp_occ = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.pc    = $urandom;
        e.instr = $urandom;
        e.rd    = RI'($urandom);
        e.rs1   = RI'($urandom);
        e.rs2   = RI'($urandom);
        e.ctrl  = CW'($urandom);
        return e;
    endfunction

    // Called just after a rising edge; holds inputs for one full cycle.
    task automatic step(input logic v, input ent_t e, input logic ordy, input logic fl);
        exp_occ        = sb_q.size();
        in_valid       = v;
        pc_in          = e.pc;
        instruction_in = e.instr;
        rd_in          = e.rd;
        rs1_in         = e.rs1;
        rs2_in         = e.rs2;
        ctrl_in        = e.ctrl;
        out_ready      = ordy;
        flush_in       = fl;
        if (v && !fl && exp_occ < 2) sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr);
        ent_t e;
        e       = rand_ent();
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

    // Monitor: state checks every cycle, payload compare on each accepted output.
    int stall_m  = 0;
    int bubble_m = 0;
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                chk("rst_pc_out", 64'(pc_out), 64'd0);
                chk("rst_instr_out", 64'(instruction_out), 64'd0);
                chk("rst_ctrl_out", 64'(ctrl_out), 64'd0);
                stall_m  = 0;
                bubble_m = 0;
`ifdef DECODE_STAGE_BUFFER_STATS_EN
                chk("rst_stall_cnt", 64'(stall_cycles_out), 64'd0);
                chk("rst_bubble_cnt", 64'(bubble_cycles_out), 64'd0);
`endif
            end else begin
                chk("out_valid", 64'(out_valid), 64'(exp_occ > 0));
                chk("in_ready", 64'(in_ready), 64'(exp_occ < 2));
                if (!out_valid) chk("bubble_ctrl_zero", 64'(ctrl_out), 64'd0);
`ifdef DECODE_STAGE_BUFFER_STATS_EN
                chk("stall_cnt", 64'(stall_cycles_out), 64'(stall_m));
                chk("bubble_cnt", 64'(bubble_cycles_out), 64'(bubble_m));
`endif
                if (exp_occ > 0 && !out_ready && stall_m < (1 << SW) - 1) stall_m++;
                if (exp_occ == 0 && bubble_m < (1 << SW) - 1) bubble_m++;
                if (flush_in) begin
                    sb_q.delete();
                end else if (exp_occ > 0 && out_ready && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("pc_out", 64'(pc_out), 64'(e.pc));
                    chk("instruction_out", 64'(instruction_out), 64'(e.instr));
                    chk("rd_out", 64'(rd_out), 64'(e.rd));
                    chk("rs1_out", 64'(rs1_out), 64'(e.rs1));
                    chk("rs2_out", 64'(rs2_out), 64'(e.rs2));
                    chk("ctrl_out", 64'(ctrl_out), 64'(e.ctrl));
                end
            end
        end
    end

    initial begin
        ent_t idle;
        idle           = '0;
        rst_n          = 1'b0;
        flush_in       = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        pc_in          = '0;
        instruction_in = '0;
        rd_in          = '0;
        rs1_in         = '0;
        rs2_in         = '0;
        ctrl_in        = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First entry: visible one cycle later.
        step(1'b1, mk(32'h100, 32'h00A00093), 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Back-to-back stream with downstream always ready.
        for (int i = 0; i < 4; i++) step(1'b1, mk(32'(i * 4), $urandom), 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Fill to FULL, push while FULL is ignored, then drain in order.
        step(1'b1, mk(32'h10, $urandom), 1'b0, 1'b0);
        step(1'b1, mk(32'h14, $urandom), 1'b0, 1'b0);
        step(1'b1, mk(32'h18, $urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, 1'b0);

        // Flush while FULL with a valid incoming entry.
        step(1'b1, mk(32'h30, $urandom), 1'b0, 1'b0);
        step(1'b1, mk(32'h34, $urandom), 1'b0, 1'b0);
        step(1'b1, mk(32'h20, $urandom), 1'b0, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);

        // Stall counter saturation, then flush must not clear it.
        step(1'b1, mk(32'h40, $urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, idle, 1'b0, 1'b0);
        step(1'b0, idle, 1'b0, 1'b1);
        step(1'b0, idle, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while BUSY.
        step(1'b1, mk(32'h50, $urandom), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_pc_out", 64'(pc_out), 64'd0);
        chk("async_rst_rd_out", 64'(rd_out), 64'd0);
        chk("async_rst_ctrl_out", 64'(ctrl_out), 64'd0);
        sb_q.delete();
        exp_occ  = 0;
        in_valid = 1'b0;
        flush_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_ent(),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, idle, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
